hdmi_island_scheduler: RTL and testbench

- Per-pixel sequencer for HDMI blanking. Decides each cycle whether the link is in control period, data-island preamble/guard/packet, or video preamble/guard/active.
- Round-robin arbitrates packet sources (audio clock regen, audio sample, infoframes, etc.) into data islands that fit in the remaining blanking.
- Sits between the video timing generator and the TMDS channel encoders/packet assembler; drives their mode selects.

---
 rtl/hdmi_island_scheduler_if.sv | 27 ++
 rtl/hdmi_island_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_island_scheduler_if.sv
// Link-side bundle between the video timing generator, packet sources and the
// HDMI island scheduler. The scheduler uses the master view; timing generator,
// packet sources and TMDS encoders use the slave view.
interface hdmi_island_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                 de;
    logic [11:0]          blank_left;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_type;
    logic [NUM_REQ-1:0]   grant;
    logic [2:0]           period;
    logic [3:0]           ctl;
    logic [7:0]           pkt_type;
    logic [4:0]           pkt_index;
    logic                 pkt_start;

    modport master (
        input  de, blank_left, req, req_type,
        output grant, period, ctl, pkt_type, pkt_index, pkt_start
    );

    modport slave (
        output de, blank_left, req, req_type,
        input  grant, period, ctl, pkt_type, pkt_index, pkt_start
    );
endinterface

// File: rtl/hdmi_island_scheduler.sv
// Per-pixel HDMI blanking sequencer: chooses control / data-island / video
// periods, round-robin arbitrates packet sources into islands that fit in the
// remaining blanking, and drives the encoder mode selects (registered, 1-cycle
// latency from de/blank_left/req).
//
// state   | meaning
// CTRL    | control period, counting toward the minimum before an island
// DI_PRE  | data-island preamble, CTL=0101
// DI_LGB  | data-island leading guard band
// DI_DATA | data-island packet pixels, grant pulses on pixel 0
// DI_TGB  | data-island trailing guard band
// VID_PRE | video preamble, CTL=0001
// VID_GB  | video leading guard band
// VIDEO   | active video
module hdmi_island_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int PACKET_LEN   = 32,
    parameter int MAX_PACKETS  = 18,
    parameter int MIN_CTRL     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    hdmi_island_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        DI_PRE  = 3'd1,
        DI_LGB  = 3'd2,
        DI_DATA = 3'd3,
        DI_TGB  = 3'd4,
        VID_PRE = 3'd5,
        VID_GB  = 3'd6,
        VIDEO   = 3'd7
    } period_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Start an island only if preamble, guards, one packet, the minimum
    // control gap and the video preamble/guard all still fit.
    localparam logic [11:0] FIT_MIN  = 12'(PREAMBLE_LEN + 2*GUARD_LEN + PACKET_LEN
                                           + MIN_CTRL + PREAMBLE_LEN + GUARD_LEN);
    // Another packet needs itself, the trailing guard and the same tail margin.
    localparam logic [11:0] CONT_MIN = 12'(PACKET_LEN + GUARD_LEN + MIN_CTRL
                                           + PREAMBLE_LEN + GUARD_LEN);
    localparam logic [11:0] GB_MAX   = 12'(GUARD_LEN);
    localparam logic [11:0] PRE_MAX  = 12'(GUARD_LEN + PREAMBLE_LEN);
    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0]  GB_LAST  = 4'(GUARD_LEN - 1);
    localparam logic [4:0]  IDX_LAST = 5'(PACKET_LEN - 1);
    localparam logic [4:0]  PKT_MAX  = 5'(MAX_PACKETS);
    localparam logic [7:0]  CTRL_MIN = 8'(MIN_CTRL);

    period_t            period_q, period_d;
    logic [3:0]         ctl_q, ctl_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         pkt_type_q, pkt_type_d;
    logic [4:0]         pkt_index_q, pkt_index_d;
    logic               pkt_start_q, pkt_start_d;
    logic [3:0]         phase_cnt_q, phase_cnt_d;
    logic [4:0]         pkt_cnt_q, pkt_cnt_d;
    logic [7:0]         ctrl_cnt_q, ctrl_cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               tg_violation_q, tg_violation_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand;
    logic               in_vid_gb, in_vid_pre;
    logic               island_fits, more_fits, take_pkt;
    logic               in_island, de_early, island_overlap;

    assign in_vid_gb   = (bus.blank_left != 12'd0) && (bus.blank_left <= GB_MAX);
    assign in_vid_pre  = (bus.blank_left > GB_MAX) && (bus.blank_left <= PRE_MAX);
    assign island_fits = (ctrl_cnt_q >= CTRL_MIN) && (|bus.req) && !bus.de
                         && (bus.blank_left >= FIT_MIN);
    assign more_fits   = arb_found && (pkt_cnt_q < PKT_MAX) && (bus.blank_left >= CONT_MIN);

    assign in_island      = period_q inside {DI_PRE, DI_LGB, DI_DATA, DI_TGB};
    assign de_early       = bus.de && (period_q != VID_GB) && (period_q != VIDEO);
    assign island_overlap = !bus.de && (in_vid_gb || in_vid_pre) && in_island;

    // Round-robin search from the pointer; the lowest offset with req set wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Next period, phase/packet counters and grant; the video path overrides all.
    always_comb begin
        period_d       = period_q;
        phase_cnt_d    = phase_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        pkt_index_d    = '0;
        pkt_start_d    = 1'b0;
        grant_d        = '0;
        pkt_type_d     = pkt_type_q;
        rr_d           = rr_q;
        take_pkt       = 1'b0;

        if (bus.de) begin
            period_d = VIDEO;
        end else if (in_vid_gb) begin
            period_d = VID_GB;
        end else if (in_vid_pre) begin
            period_d = VID_PRE;
        end else begin
            case (period_q)
                CTRL: begin
                    if (island_fits) begin
                        period_d    = DI_PRE;
                        phase_cnt_d = PRE_LAST;
                    end
                end
                DI_PRE: begin
                    if (phase_cnt_q == 4'd0) begin
                        period_d    = DI_LGB;
                        phase_cnt_d = GB_LAST;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 4'd1;
                    end
                end
                DI_LGB: begin
                    if (phase_cnt_q != 4'd0) begin
                        phase_cnt_d = phase_cnt_q - 4'd1;
                    end else if (arb_found) begin
                        take_pkt  = 1'b1;
                        pkt_cnt_d = 5'd1;
                    end else begin
                        // everyone withdrew after the fit check: close the island
                        period_d    = DI_TGB;
                        phase_cnt_d = GB_LAST;
                    end
                end
                DI_DATA: begin
                    if (pkt_index_q != IDX_LAST) begin
                        pkt_index_d = pkt_index_q + 5'd1;
                    end else if (more_fits) begin
                        take_pkt  = 1'b1;
                        pkt_cnt_d = pkt_cnt_q + 5'd1;
                    end else begin
                        period_d    = DI_TGB;
                        phase_cnt_d = GB_LAST;
                    end
                end
                DI_TGB: begin
                    if (phase_cnt_q == 4'd0) begin
                        period_d = CTRL;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 4'd1;
                    end
                end
                default: period_d = CTRL;
            endcase

            if (take_pkt) begin
                period_d    = DI_DATA;
                pkt_start_d = 1'b1;
                grant_d     = NUM_REQ'(1) << arb_idx;
                pkt_type_d  = bus.req_type[{arb_idx, 3'b000} +: 8];
                rr_d        = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
            end
        end
    end

    // Mode selects, control-period counter and the sticky timing-violation flag.
    always_comb begin
        ctl_d = 4'b0000;
        if (period_d == DI_PRE) begin
            ctl_d = 4'b0101;
        end else if (period_d == VID_PRE) begin
            ctl_d = 4'b0001;
        end
        ctrl_cnt_d = 8'd0;
        if (period_d == CTRL) begin
            ctrl_cnt_d = (ctrl_cnt_q == 8'hFF) ? ctrl_cnt_q : ctrl_cnt_q + 8'd1;
        end
        tg_violation_d = tg_violation_q | de_early;
    end

    // State and registered outputs; reset aborts any island on the spot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q       <= CTRL;
            ctl_q          <= '0;
            grant_q        <= '0;
            pkt_type_q     <= '0;
            pkt_index_q    <= '0;
            pkt_start_q    <= 1'b0;
            phase_cnt_q    <= '0;
            pkt_cnt_q      <= '0;
            ctrl_cnt_q     <= '0;
            rr_q           <= '0;
            tg_violation_q <= 1'b0;
        end else begin
            period_q       <= period_d;
            ctl_q          <= ctl_d;
            grant_q        <= grant_d;
            pkt_type_q     <= pkt_type_d;
            pkt_index_q    <= pkt_index_d;
            pkt_start_q    <= pkt_start_d;
            phase_cnt_q    <= phase_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            ctrl_cnt_q     <= ctrl_cnt_d;
            rr_q           <= rr_d;
            tg_violation_q <= tg_violation_d;
        end
    end

    // Runtime guards: de outside the video guard band is a timing-generator
    // fault; an island still running inside the video window is our own bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!de_early)
                else $warning("de raised outside VID_GB/VIDEO, island aborted");
            assert (!island_overlap)
                else $error("data island overlaps video preamble window");
        end
    end

    assign bus.period    = period_q;
    assign bus.ctl       = ctl_q;
    assign bus.grant     = grant_q;
    assign bus.pkt_type  = pkt_type_q;
    assign bus.pkt_index = pkt_index_q;
    assign bus.pkt_start = pkt_start_q;
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for the HDMI island scheduler.
module tb_hdmi_island_scheduler;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    int n, cnt, gcount, gcyc, idx31, tt, ctrl_gap, done, seen_tgb, pre_seen;
    logic [3:0] gval;
    logic [7:0] ptype;
    logic [2:0] obs_p [0:161];
    logic [3:0] obs_c [0:161];
    int seg_p [10];
    int seg_n [10];
    logic [3:0] gq [$];

    hdmi_island_scheduler_if #(.NUM_REQ(4)) bus ();

    hdmi_island_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until DI_DATA shows the given pixel index, bounded.
    task automatic run_to_index(input logic [4:0] idx, input string tag);
        int k;
        k = 0;
        while (!(bus.period == 3'd3 && bus.pkt_index == idx) && k < 2000) begin
            step();
            k++;
        end
        chk(tag, 32'(bus.period == 3'd3 && bus.pkt_index == idx), 1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.de         = 1'b0;
        bus.blank_left = 12'd0;
        bus.req        = 4'b0000;
        bus.req_type   = {8'h84, 8'h82, 8'h02, 8'h01};
        seg_p = '{7, 0,  1, 2,  3, 4,  0, 5, 6, 7};
        seg_n = '{1, 12, 8, 2, 32, 2, 94, 8, 2, 1};

        // reset state
        step();
        step();
        chk("rst_period", bus.period, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_pkt_index", bus.pkt_index, 0);
        chk("rst_ctl", bus.ctl, 0);
        chk("rst_pkt_start", bus.pkt_start, 0);
        rst = 1'b0;

        // short blank into video so the main test starts from VIDEO
        for (int b = 10; b >= 1; b--) begin
            bus.blank_left = 12'(b);
            step();
        end
        bus.de = 1'b1;
        bus.blank_left = 12'd0;
        step();
        chk("pre_video", bus.period, 7);
        step();

        // 160-cycle blank with one packet from requester 0
        bus.req = 4'b0001;
        gcount = 0; gcyc = -1; idx31 = -1; gval = '0; ptype = '0;
        for (int t = 0; t < 162; t++) begin
            obs_p[t] = bus.period;
            obs_c[t] = bus.ctl;
            if (bus.grant != 4'b0000) begin
                gcount++;
                gval  = bus.grant;
                gcyc  = t;
                ptype = bus.pkt_type;
                bus.req = 4'b0000;
            end
            if (bus.period == 3'd3 && bus.pkt_index == 5'd31) idx31 = t;
            if (t < 160) begin
                bus.de = 1'b0;
                bus.blank_left = 12'(160 - t);
            end else begin
                bus.de = 1'b1;
                bus.blank_left = 12'd0;
            end
            step();
        end
        tt = 0;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < seg_n[s]; j++) begin
                chk("t2_period", obs_p[tt], seg_p[s]);
                chk("t2_ctl", obs_c[tt], (seg_p[s] == 1) ? 5 : (seg_p[s] == 5) ? 1 : 0);
                tt++;
            end
        end
        chk("t2_grant_count", gcount, 1);
        chk("t2_grant_value", gval, 4'b0001);
        chk("t2_grant_cycle", gcyc, 23);
        chk("t2_pkt_type", ptype, 8'h01);
        chk("t2_last_pixel_cycle", idx31, 54);

        // reset in the middle of a packet (pkt_index 17)
        bus.de = 1'b0;
        bus.blank_left = 12'd1000;
        bus.req = 4'b0010;
        run_to_index(5'd17, "t1_reach_idx17");
        chk("t1_pkt_type", bus.pkt_type, 8'h02);
        rst = 1'b1;
        #1;
        chk("t1_async_period", bus.period, 0);
        chk("t1_async_grant", bus.grant, 0);
        chk("t1_async_pkt_index", bus.pkt_index, 0);
        chk("t1_async_pkt_type", bus.pkt_type, 0);
        step();
        rst = 1'b0;
        n = 0; cnt = 0;
        while (bus.period != 3'd1 && n < 100) begin
            step();
            n++;
            if (bus.period == 3'd0) cnt++;
        end
        chk("t1_di_pre_reached", bus.period, 1);
        chk("t1_ctrl_before_pre", cnt, 12);

        // all four requesting, long blank: rotation, 18-packet cap, CTRL gap
        bus.req = 4'b1111;
        bus.blank_left = 12'd1000;
        do_reset();
        gq.delete();
        done = 0; seen_tgb = 0; ctrl_gap = 0;
        for (int t = 0; t < 1000 && done == 0; t++) begin
            step();
            if (bus.grant != 4'b0000 && seen_tgb == 0) gq.push_back(bus.grant);
            if (bus.period == 3'd4) seen_tgb = 1;
            if (seen_tgb == 1 && bus.period == 3'd0) ctrl_gap++;
            if (seen_tgb == 1 && bus.period == 3'd1) done = 1;
        end
        chk("t3_second_island", done, 1);
        chk("t3_packets", gq.size(), 18);
        for (int i = 0; i < 18 && i < gq.size(); i++) begin
            chk("t3_grant_rotation", gq[i], 32'(4'b0001 << (i % 4)));
        end
        chk("t3_ctrl_gap", ctrl_gap, 12);

        // fit boundary: 65 is one short, 66 starts the preamble next cycle
        bus.req = 4'b0001;
        bus.blank_left = 12'd65;
        do_reset();
        pre_seen = 0;
        for (int t = 0; t < 30; t++) begin
            step();
            if (bus.period != 3'd0) pre_seen++;
        end
        chk("t4_no_island_at_65", pre_seen, 0);
        bus.blank_left = 12'd66;
        step();
        chk("t4_di_pre_at_66", bus.period, 1);
        chk("t4_ctl_at_66", bus.ctl, 4'b0101);

        // second packet, then requester drops at the last pixel
        bus.blank_left = 12'd1000;
        bus.req = 4'b0001;
        do_reset();
        run_to_index(5'd31, "t5_first_end");
        step();
        chk("t5_second_start", bus.pkt_start, 1);
        chk("t5_second_grant", bus.grant, 4'b0001);
        chk("t5_second_index", bus.pkt_index, 0);
        run_to_index(5'd31, "t5_second_end");
        bus.req = 4'b0000;
        step();
        chk("t5_tgb1", bus.period, 4);
        chk("t5_tgb1_grant", bus.grant, 0);
        step();
        chk("t5_tgb2", bus.period, 4);
        chk("t5_tgb2_grant", bus.grant, 0);
        step();
        chk("t5_ctrl", bus.period, 0);
        chk("t5_ctrl_grant", bus.grant, 0);

        // de forced during a packet
        bus.req = 4'b0001;
        bus.blank_left = 12'd1000;
        do_reset();
        run_to_index(5'd5, "t6_reach_idx5");
        chk("t6_flag_clear", dut.tg_violation_q, 0);
        bus.de = 1'b1;
        bus.blank_left = 12'd0;
        step();
        chk("t6_video", bus.period, 7);
        chk("t6_pkt_start", bus.pkt_start, 0);
        chk("t6_grant", bus.grant, 0);
        chk("t6_pkt_index", bus.pkt_index, 0);
        chk("t6_flag_set", dut.tg_violation_q, 1);
        bus.de = 1'b0;
        bus.blank_left = 12'd1000;
        step();
        chk("t6_back_to_ctrl", bus.period, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
